mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-client arbiter between the instruction cache and data cache miss/write-through ports and the single shared external memory interface. Each cache sees a private copy of the word-granular memory port (ready/addr/ren/wen/wdata/rdata/valid), and the arbiter serialises their requests onto the real memory. It tracks the one outstanding read and steers the response back to the cache that issued it.

## Interface
Parameters:
- none; widths are fixed at 32-bit address/data.

Ports:
- i_clk  in  1  global clock
- i_rst  in  1  synchronous, active-high reset
- i_ic_addr  in  32  icache request address, word aligned
- i_ic_ren  in  1  icache read request
- i_ic_wen  in  1  icache write request; tie 0 in normal use but honoured
- i_ic_wdata  in  32  icache write data
- o_ic_ready  out  1  icache request accepted this cycle if ren/wen high
- o_ic_rdata  out  32  read data, a copy of i_mem_rdata
- o_ic_valid  out  1  icache read response valid
- i_dc_addr, i_dc_ren, i_dc_wen, i_dc_wdata, o_dc_ready, o_dc_rdata, o_dc_valid: same as the icache ports, for the dcache
- i_mem_ready  in  1  memory can accept a request
- o_mem_addr  out  32  forwarded address
- o_mem_ren  out  1  forwarded read
- o_mem_wen  out  1  forwarded write
- o_mem_wdata  out  32  forwarded write data
- i_mem_rdata  in  32  memory read data
- i_mem_valid  in  1  memory read response valid

## Operation
- Transfer rule: a request transfers on a cycle where ren or wen is high and ready is high.
- Writes are posted: they complete on acceptance and get no valid response.
- Reads complete on i_mem_valid.
- State IDLE:
  - Grant is computed combinationally from the current requests.
  - The granted client's addr/wdata/ren/wen are driven to memory.
  - The granted client's ready = i_mem_ready. The other client's ready = 0.
- IDLE -> READ_WAIT on an accepted read; the owner register records the granting client.
- An accepted write stays in IDLE; the next request may issue the following cycle.
- State READ_WAIT:
  - o_mem_ren = o_mem_wen = 0; both readys = 0.
  - The owner's valid = i_mem_valid; the other client's valid = 0.
  - READ_WAIT -> IDLE on i_mem_valid.
- o_ic_rdata and o_dc_rdata are always i_mem_rdata. Consumers qualify them with their own valid.
- Arbitration (default is round-robin):
  - A last-served bit updates on every accepted request.
  - When both clients request, the client not served last wins. A single requester always wins.
  - Grant does not change while a client holds its request with i_mem_ready low. The decision is re-evaluated each cycle, but the last-served bit only moves on transfer.
- Idle mux: with no request, o_mem_addr/o_mem_wdata show the last-served client's lines, and ren/wen = 0.
- A client asserting ren and wen together is illegal. The arbiter forwards both unchanged and does not check.
- A stray i_mem_valid in IDLE is ignored: no client valid is raised.

## Timing
- Reset values:
  - state = IDLE, last-served = icache.
  - o_mem_ren/o_mem_wen = 0 and o_ic_valid/o_dc_valid = 0 while the inputs are idle.
  - All readys are combinational from i_mem_ready.
- Zero added request latency: a client request appears on o_mem_* in the same cycle.
- Zero added response latency: o_*_valid is combinational from i_mem_valid.
- Back-to-back reads: if the response arrives in cycle N, the next read can be accepted in cycle N+1, never N. Ready is held low for all of READ_WAIT, including the valid cycle.
- Reset mid-read: return to IDLE. A memory response for the dropped read that arrives later is ignored per the stray rule.
- Simultaneous icache read and dcache write with ready high: exactly one transfers per the arbitration policy. The loser sees ready = 0 and keeps requesting.

## Configuration
- MEM_ARB_DCACHE_PRIORITY_EN
  - Defined: fixed priority; the dcache always wins when both request, and the last-served bit is unused.
  - Undefined: round-robin as above.

## Structure
- Package mem_arb_pkg:
  - state_t enum {IDLE, READ_WAIT}.
  - Client index localparams CLIENT_IC = 1'b0 and CLIENT_DC = 1'b1.
- Sub-module arb_pick2: a pure combinational grant picker with inputs req[1:0], last and a priority mode, and output grant. It is the only sub-module; the FSM and muxes stay in mem_arbiter.

## Test plan
- Icache read only, addr 0x100, memory ready, valid after 3 cycles with rdata 0xDEADBEEF:
  - 0x100 appears on o_mem_addr the same cycle.
  - o_ic_valid = 1 with rdata 0xDEADBEEF; o_dc_valid stays 0.
- Both clients read together, addresses 0x200 (icache) and 0x300 (dcache), after reset:
  - Round-robin: the dcache is served first (last-served = icache), then the icache is accepted the cycle after the first response.
  - With the macro defined: the dcache is served first on every repeat.
- Dcache write 0x40 / 0x12345678 while ready is low for 2 cycles:
  - o_dc_ready = 0 for those cycles.
  - Transfer happens in cycle 3 with no o_dc_valid.
  - State stays IDLE, and an icache read is accepted in cycle 4.
- Icache read outstanding, dcache requests a read:
  - o_dc_ready stays 0 until the cycle after i_mem_valid.
  - o_mem_ren = 0 throughout READ_WAIT.
- i_rst pulsed during READ_WAIT, then i_mem_valid arrives:
  - Neither o_ic_valid nor o_dc_valid is raised.
  - The next request is accepted immediately.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-client memory arbiter.
package mem_arb_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    typedef enum logic {
        IDLE      = 1'b0,
        READ_WAIT = 1'b1
    } state_t;

    localparam logic CLIENT_IC = 1'b0;
    localparam logic CLIENT_DC = 1'b1;

endpackage

// File: rtl/arb_pick2.sv
// Combinational two-way grant picker: round-robin on last-served, or fixed
// dcache priority when prio_dc_i is set. With no request the grant rests on
// the last-served client so the idle memory lines follow it.
module arb_pick2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       last_i,
    input  logic       prio_dc_i,
    output logic       grant_o
);

    // Pick the winner from the current requests
    always_comb begin
        grant_o = last_i;
        if (req_i == 2'b11) begin
            grant_o = prio_dc_i ? CLIENT_DC : ~last_i;
        end else if (req_i[CLIENT_DC]) begin
            grant_o = CLIENT_DC;
        end else if (req_i[CLIENT_IC]) begin
            grant_o = CLIENT_IC;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises icache and dcache requests onto one memory port, tracks the
// single outstanding read and steers its response back to the issuer.
// Build option: MEM_ARB_DCACHE_PRIORITY_EN selects fixed dcache priority
// instead of round-robin arbitration.
module mem_arbiter
    import mem_arb_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [ADDR_W-1:0] i_ic_addr,
    input  logic              i_ic_ren,
    input  logic              i_ic_wen,
    input  logic [DATA_W-1:0] i_ic_wdata,
    output logic              o_ic_ready,
    output logic [DATA_W-1:0] o_ic_rdata,
    output logic              o_ic_valid,
    input  logic [ADDR_W-1:0] i_dc_addr,
    input  logic              i_dc_ren,
    input  logic              i_dc_wen,
    input  logic [DATA_W-1:0] i_dc_wdata,
    output logic              o_dc_ready,
    output logic [DATA_W-1:0] o_dc_rdata,
    output logic              o_dc_valid,
    input  logic              i_mem_ready,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic              o_mem_ren,
    output logic              o_mem_wen,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata,
    input  logic              i_mem_valid
);

`ifdef MEM_ARB_DCACHE_PRIORITY_EN
    localparam logic PRIO_DC = 1'b1;
`else
    localparam logic PRIO_DC = 1'b0;
`endif

    state_t state_q, state_d;
    logic   last_q,  last_d;
    logic   owner_q, owner_d;
    logic   grant;
    logic   g_ren;
    logic   g_wen;
    logic   xfer;

    arb_pick2 u_pick (
        .req_i     ({i_dc_ren | i_dc_wen, i_ic_ren | i_ic_wen}),
        .last_i    (last_q),
        .prio_dc_i (PRIO_DC),
        .grant_o   (grant)
    );

    assign g_ren = (grant == CLIENT_DC) ? i_dc_ren : i_ic_ren;
    assign g_wen = (grant == CLIENT_DC) ? i_dc_wen : i_ic_wen;
    assign xfer  = (state_q == IDLE) && (g_ren || g_wen) && i_mem_ready;

    // State, last-served and read-owner registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            last_q  <= CLIENT_IC;
            owner_q <= CLIENT_IC;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            owner_q <= owner_d;
        end
    end

    // Next state: accepted reads wait for the response, posted writes do not
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        owner_d = owner_q;
        unique case (state_q)
            IDLE: begin
                if (xfer) begin
                    last_d = grant;
                    if (g_ren) begin
                        state_d = READ_WAIT;
                        owner_d = grant;
                    end
                end
            end
            READ_WAIT: begin
                if (i_mem_valid) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs: request mux in IDLE, response steering in READ_WAIT
    always_comb begin
        o_mem_addr  = (grant == CLIENT_DC) ? i_dc_addr  : i_ic_addr;
        o_mem_wdata = (grant == CLIENT_DC) ? i_dc_wdata : i_ic_wdata;
        o_mem_ren   = 1'b0;
        o_mem_wen   = 1'b0;
        o_ic_ready  = 1'b0;
        o_dc_ready  = 1'b0;
        o_ic_valid  = 1'b0;
        o_dc_valid  = 1'b0;
        o_ic_rdata  = i_mem_rdata;
        o_dc_rdata  = i_mem_rdata;
        unique case (state_q)
            IDLE: begin
                o_mem_ren = g_ren;
                o_mem_wen = g_wen;
                if (grant == CLIENT_DC) begin
                    o_dc_ready = i_mem_ready;
                end else begin
                    o_ic_ready = i_mem_ready;
                end
            end
            READ_WAIT: begin
                o_ic_valid = i_mem_valid && (owner_q == CLIENT_IC);
                o_dc_valid = i_mem_valid && (owner_q == CLIENT_DC);
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: single reads, contention, stalled posted
// write, read blocking and reset during an outstanding read.
module tb_mem_arbiter;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic [31:0] i_ic_addr, i_ic_wdata, i_dc_addr, i_dc_wdata;
    logic        i_ic_ren, i_ic_wen, i_dc_ren, i_dc_wen;
    logic        o_ic_ready, o_ic_valid, o_dc_ready, o_dc_valid;
    logic [31:0] o_ic_rdata, o_dc_rdata;
    logic        i_mem_ready, i_mem_valid;
    logic [31:0] o_mem_addr, o_mem_wdata, i_mem_rdata;
    logic        o_mem_ren, o_mem_wen;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] exp_addr;
    logic        exp_icv;
    logic        exp_dcv;

    mem_arbiter dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_ic_addr   (i_ic_addr),
        .i_ic_ren    (i_ic_ren),
        .i_ic_wen    (i_ic_wen),
        .i_ic_wdata  (i_ic_wdata),
        .o_ic_ready  (o_ic_ready),
        .o_ic_rdata  (o_ic_rdata),
        .o_ic_valid  (o_ic_valid),
        .i_dc_addr   (i_dc_addr),
        .i_dc_ren    (i_dc_ren),
        .i_dc_wen    (i_dc_wen),
        .i_dc_wdata  (i_dc_wdata),
        .o_dc_ready  (o_dc_ready),
        .o_dc_rdata  (o_dc_rdata),
        .o_dc_valid  (o_dc_valid),
        .i_mem_ready (i_mem_ready),
        .o_mem_addr  (o_mem_addr),
        .o_mem_ren   (o_mem_ren),
        .o_mem_wen   (o_mem_wen),
        .o_mem_wdata (o_mem_wdata),
        .i_mem_rdata (i_mem_rdata),
        .i_mem_valid (i_mem_valid)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        i_rst = 1'b1;
        i_ic_addr = 32'hAAA0; i_ic_ren = 1'b0; i_ic_wen = 1'b0; i_ic_wdata = 32'h0;
        i_dc_addr = 32'hBBB0; i_dc_ren = 1'b0; i_dc_wen = 1'b0; i_dc_wdata = 32'h0;
        i_mem_ready = 1'b1; i_mem_valid = 1'b0; i_mem_rdata = 32'h0;
        tick(); tick();
        i_rst = 1'b0;
        settle();
        chk("rst_mem_ren", 32'(o_mem_ren), 32'd0);
        chk("rst_mem_wen", 32'(o_mem_wen), 32'd0);
        chk("rst_ic_valid", 32'(o_ic_valid), 32'd0);
        chk("rst_dc_valid", 32'(o_dc_valid), 32'd0);
        chk("rst_idle_addr_ic", o_mem_addr, 32'hAAA0);

        // Icache read 0x100, response three cycles later
        tick();
        i_ic_addr = 32'h100; i_ic_ren = 1'b1;
        settle();
        chk("t1_addr", o_mem_addr, 32'h100);
        chk("t1_ren", 32'(o_mem_ren), 32'd1);
        chk("t1_ic_ready", 32'(o_ic_ready), 32'd1);
        chk("t1_dc_ready", 32'(o_dc_ready), 32'd0);
        tick();
        i_ic_ren = 1'b0;
        settle();
        chk("t1_w1_ren", 32'(o_mem_ren), 32'd0);
        chk("t1_w1_icv", 32'(o_ic_valid), 32'd0);
        tick();
        settle();
        chk("t1_w2_icv", 32'(o_ic_valid), 32'd0);
        tick();
        i_mem_valid = 1'b1; i_mem_rdata = 32'hDEADBEEF; i_ic_ren = 1'b1;
        settle();
        chk("t1_icv", 32'(o_ic_valid), 32'd1);
        chk("t1_rdata", o_ic_rdata, 32'hDEADBEEF);
        chk("t1_dcv", 32'(o_dc_valid), 32'd0);
        chk("t1_ready_in_valid", 32'(o_ic_ready), 32'd0);
        tick();
        i_mem_valid = 1'b0; i_ic_ren = 1'b0;

        // Both read after reset: dcache first, icache right after
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        i_ic_addr = 32'h200; i_ic_ren = 1'b1;
        i_dc_addr = 32'h300; i_dc_ren = 1'b1;
        settle();
        chk("t2_first_addr", o_mem_addr, 32'h300);
        chk("t2_dc_ready", 32'(o_dc_ready), 32'd1);
        chk("t2_ic_ready", 32'(o_ic_ready), 32'd0);
        tick();
        i_dc_ren = 1'b0;
        settle();
        chk("t2_w_ic_ready", 32'(o_ic_ready), 32'd0);
        chk("t2_w_ren", 32'(o_mem_ren), 32'd0);
        tick();
        i_mem_valid = 1'b1; i_mem_rdata = 32'h11;
        settle();
        chk("t2_dcv", 32'(o_dc_valid), 32'd1);
        chk("t2_icv", 32'(o_ic_valid), 32'd0);
        chk("t2_ic_ready_valid", 32'(o_ic_ready), 32'd0);
        tick();
        i_mem_valid = 1'b0;
        settle();
        chk("t2_second_addr", o_mem_addr, 32'h200);
        chk("t2_second_ic_ready", 32'(o_ic_ready), 32'd1);
        tick();
        i_ic_ren = 1'b0;
        tick();
        i_mem_valid = 1'b1; i_mem_rdata = 32'h22;
        settle();
        chk("t2_second_icv", 32'(o_ic_valid), 32'd1);
        chk("t2_second_dcv", 32'(o_dc_valid), 32'd0);
        tick();
        i_mem_valid = 1'b0;

        // Contention again with last-served = icache, then with last = dcache
        i_ic_addr = 32'h204; i_ic_ren = 1'b1;
        i_dc_addr = 32'h304; i_dc_ren = 1'b1;
        settle();
        chk("t2_rep_addr", o_mem_addr, 32'h304);
        tick();
        i_dc_ren = 1'b0;
        tick();
        i_mem_valid = 1'b1;
        tick();
        i_mem_valid = 1'b0;
        i_dc_addr = 32'h308; i_dc_ren = 1'b1;
`ifdef MEM_ARB_DCACHE_PRIORITY_EN
        exp_addr = 32'h308; exp_icv = 1'b0; exp_dcv = 1'b1;
`else
        exp_addr = 32'h204; exp_icv = 1'b1; exp_dcv = 1'b0;
`endif
        settle();
        chk("t2_policy_addr", o_mem_addr, exp_addr);
        tick();
        i_ic_ren = 1'b0; i_dc_ren = 1'b0;
        tick();
        i_mem_valid = 1'b1;
        settle();
        chk("t2_policy_icv", 32'(o_ic_valid), 32'(exp_icv));
        chk("t2_policy_dcv", 32'(o_dc_valid), 32'(exp_dcv));
        tick();
        i_mem_valid = 1'b0;

        // Dcache write stalled two cycles by memory
        i_mem_ready = 1'b0;
        i_dc_addr = 32'h40; i_dc_wdata = 32'h12345678; i_dc_wen = 1'b1;
        settle();
        chk("t3_c1_dc_ready", 32'(o_dc_ready), 32'd0);
        chk("t3_c1_wen", 32'(o_mem_wen), 32'd1);
        chk("t3_c1_addr", o_mem_addr, 32'h40);
        chk("t3_c1_wdata", o_mem_wdata, 32'h12345678);
        tick();
        settle();
        chk("t3_c2_dc_ready", 32'(o_dc_ready), 32'd0);
        tick();
        i_mem_ready = 1'b1;
        settle();
        chk("t3_c3_dc_ready", 32'(o_dc_ready), 32'd1);
        chk("t3_c3_dcv", 32'(o_dc_valid), 32'd0);
        tick();
        i_dc_wen = 1'b0;
        i_ic_addr = 32'h500; i_ic_ren = 1'b1;
        settle();
        chk("t3_c4_ic_ready", 32'(o_ic_ready), 32'd1);
        chk("t3_c4_addr", o_mem_addr, 32'h500);
        chk("t3_c4_ren", 32'(o_mem_ren), 32'd1);
        chk("t3_c4_dcv", 32'(o_dc_valid), 32'd0);

        // Icache read outstanding while dcache requests a read
        tick();
        i_ic_ren = 1'b0;
        i_dc_addr = 32'h600; i_dc_ren = 1'b1;
        settle();
        chk("t4_w1_dc_ready", 32'(o_dc_ready), 32'd0);
        chk("t4_w1_ren", 32'(o_mem_ren), 32'd0);
        tick();
        settle();
        chk("t4_w2_dc_ready", 32'(o_dc_ready), 32'd0);
        chk("t4_w2_ren", 32'(o_mem_ren), 32'd0);
        tick();
        i_mem_valid = 1'b1; i_mem_rdata = 32'h55;
        settle();
        chk("t4_v_icv", 32'(o_ic_valid), 32'd1);
        chk("t4_v_dcv", 32'(o_dc_valid), 32'd0);
        chk("t4_v_dc_ready", 32'(o_dc_ready), 32'd0);
        chk("t4_v_ren", 32'(o_mem_ren), 32'd0);
        tick();
        i_mem_valid = 1'b0;
        settle();
        chk("t4_next_dc_ready", 32'(o_dc_ready), 32'd1);
        chk("t4_next_addr", o_mem_addr, 32'h600);

        // Reset while the dcache read is outstanding, then a stray response
        tick();
        i_dc_ren = 1'b0;
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        i_mem_valid = 1'b1;
        settle();
        chk("t5_stray_icv", 32'(o_ic_valid), 32'd0);
        chk("t5_stray_dcv", 32'(o_dc_valid), 32'd0);
        tick();
        i_mem_valid = 1'b0;
        i_ic_addr = 32'h700; i_ic_ren = 1'b1;
        settle();
        chk("t5_next_ic_ready", 32'(o_ic_ready), 32'd1);
        chk("t5_next_addr", o_mem_addr, 32'h700);
        tick();
        i_ic_ren = 1'b0;
        i_mem_valid = 1'b1; i_mem_rdata = 32'h77;
        settle();
        chk("t5_resp_icv", 32'(o_ic_valid), 32'd1);
        chk("t5_resp_dcv", 32'(o_dc_valid), 32'd0);
        tick();
        i_mem_valid = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
